// File: rtl/ecall_uart_pkg.sv
// Shared types and defaults for the ecall UART sink.
package ecall_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int unsigned DEF_CLK_DIV    = 434;
    localparam int unsigned DEF_FIFO_DEPTH = 8;
    localparam int unsigned DEF_FIFO_AW    = 3;

    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BITS_PER_BYTE  = 8;
    localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a synchronous active-high reset. A push while full
// is accepted only when a pop happens at the same edge.
module sync_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign wr_en   = push && (!full || pop);
    assign rd_en   = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
        end
    end

    // Storage write; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/ecall_uart_tx.sv
// Buffers 32-bit ecall words and serialises each one as four 8N1 UART
// bytes, little-endian, LSB first. Words arriving while full are dropped.
module ecall_uart_tx
    import ecall_uart_pkg::*;
#(
    parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned FIFO_AW    = DEF_FIFO_AW
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_ecall_valid,
    input  logic [31:0]        i_ecall_data,
    output logic               o_uart_tx,
    output logic               o_busy,
    output logic               o_overflow,
    output logic [FIFO_AW:0]   o_fifo_count
);

    localparam int unsigned BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    tx_state_t           state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [1:0]          byte_q, byte_d;
    logic [WORD_W-1:0]   sh_q, sh_d;
    logic                tx_d;
    logic                busy_d;
    logic                baud_end;

    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [WORD_W-1:0]   fifo_rd_data;
    logic [FIFO_AW:0]    fifo_count;
    logic                push_ok;
    logic                drop;
    logic [FIFO_AW:0]    count_nxt;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk     (i_clk),
        .rst     (i_rst),
        .push    (i_ecall_valid),
        .pop     (fifo_pop),
        .wr_data (i_ecall_data),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign baud_end  = (baud_q == BAUD_W'(CLK_DIV - 1));
    assign push_ok   = i_ecall_valid && (!fifo_full || fifo_pop);
    assign drop      = i_ecall_valid && fifo_full && !fifo_pop;
    assign count_nxt = fifo_count + {{FIFO_AW{1'b0}}, push_ok}
                                  - {{FIFO_AW{1'b0}}, fifo_pop};

    // Next-state, counters, shift register and FIFO pop decision.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        sh_d     = sh_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    sh_d     = fifo_rd_data;
                    byte_d   = '0;
                    baud_d   = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    // Shifting every bit leaves the next byte in sh[7:0].
                    sh_d   = sh_q >> 1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (byte_q != 2'd3) begin
                        byte_d  = byte_q + 2'd1;
                        state_d = START;
                    end else if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        sh_d     = fifo_rd_data;
                        byte_d   = '0;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level and busy flag derived from the upcoming state so both register cleanly.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = sh_d[0];
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE) || (count_nxt != '0);
    end

    // State, counters and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            byte_q     <= '0;
            sh_q       <= '0;
            o_uart_tx  <= 1'b1;
            o_busy     <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            sh_q       <= sh_d;
            o_uart_tx  <= tx_d;
            o_busy     <= busy_d;
            if (drop) o_overflow <= 1'b1;
        end
    end

    assign o_fifo_count = fifo_count;

endmodule

// File: tb/tb_ecall_uart_tx.sv
// Randomised and directed bench for ecall_uart_tx, checked every cycle
// against a queue-based model of the expected line bitstream.
module tb_ecall_uart_tx;

    localparam int CD    = 4;
    localparam int DEPTH = 8;
    localparam int WORDC = 40 * CD;
    localparam int HMAX  = 32768;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_ecall_valid;
    logic [31:0] i_ecall_data;
    logic        o_uart_tx;
    logic        o_busy;
    logic        o_overflow;
    logic [3:0]  o_fifo_count;

    int vectors = 0;
    int miscompares = 0;

    // Model state
    bit          line_q[$];
    logic [31:0] fifo_q[$];
    int          ecount = 0;
    logic        m_tx = 1'b1;
    logic        m_busy = 1'b0;
    logic        m_ovf = 1'b0;
    int          m_cnt = 0;

    logic tx_hist   [HMAX];
    logic busy_hist [HMAX];

    ecall_uart_tx #(
        .CLK_DIV    (CD),
        .FIFO_DEPTH (DEPTH),
        .FIFO_AW    (3)
    ) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_ecall_valid (i_ecall_valid),
        .i_ecall_data  (i_ecall_data),
        .o_uart_tx     (o_uart_tx),
        .o_busy        (o_busy),
        .o_overflow    (o_overflow),
        .o_fifo_count  (o_fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, ecount);
        end
    endtask

    // Model: the line is a queue of per-cycle levels; a word expands to 40 bit times.
    always @(posedge clk) begin
        logic [31:0] w;
        ecount++;
        if (i_rst) begin
            line_q.delete();
            fifo_q.delete();
            m_ovf = 1'b0;
        end else begin
            if (line_q.size() > 0) void'(line_q.pop_front());
            if (line_q.size() == 0 && fifo_q.size() > 0) begin
                w = fifo_q.pop_front();
                for (int n = 0; n < 4; n++) begin
                    for (int k = 0; k < CD; k++) line_q.push_back(1'b0);
                    for (int j = 0; j < 8; j++)
                        for (int k = 0; k < CD; k++) line_q.push_back(w[8*n+j]);
                    for (int k = 0; k < CD; k++) line_q.push_back(1'b1);
                end
            end
            if (i_ecall_valid) begin
                if (fifo_q.size() < DEPTH) fifo_q.push_back(i_ecall_data);
                else m_ovf = 1'b1;
            end
        end
        m_tx   = (line_q.size() > 0) ? line_q[0] : 1'b1;
        m_busy = (line_q.size() > 0) || (fifo_q.size() > 0);
        m_cnt  = fifo_q.size();
    end

    // Per-cycle comparison of all outputs, away from the active edge.
    always @(negedge clk) begin
        if (ecount > 0) begin
            check("tx",       {31'd0, o_uart_tx},  {31'd0, m_tx});
            check("busy",     {31'd0, o_busy},     {31'd0, m_busy});
            check("overflow", {31'd0, o_overflow}, {31'd0, m_ovf});
            check("count",    {28'd0, o_fifo_count}, 32'(m_cnt));
            if (ecount < HMAX) begin
                tx_hist[ecount]   = o_uart_tx;
                busy_hist[ecount] = o_busy;
            end
        end
    end

    task automatic tick(input logic v, input logic [31:0] d);
        i_ecall_valid = v;
        i_ecall_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        tick(1'b0, '0);
        i_rst = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (o_busy && n < max) begin
            tick(1'b0, '0);
            n++;
        end
        check("wait_idle_timeout", {31'd0, o_busy}, 32'd0);
        repeat (2) tick(1'b0, '0);
    endtask

    function automatic logic [31:0] decode(input int e1);
        logic [31:0] w;
        for (int n = 0; n < 4; n++)
            for (int j = 0; j < 8; j++)
                w[8*n+j] = tx_hist[e1 + n*40*CD/4*4/CD*CD/CD*0 + (n*10 + 1 + j)*CD + CD/2];
        return w;
    endfunction

    task automatic check_frames(input string name, input int e1, input int nframes);
        for (int f = 0; f < nframes; f++) begin
            check({name, "_start"}, {31'd0, tx_hist[e1 + f*10*CD + CD/2]}, 32'd0);
            check({name, "_stop"},  {31'd0, tx_hist[e1 + f*10*CD + 9*CD + CD/2]}, 32'd1);
        end
    endtask

    initial begin
        int e1;
        logic [31:0] words [11];

        i_rst = 1'b1;
        i_ecall_valid = 1'b0;
        i_ecall_data = '0;

        // 1: reset, then quiet line
        repeat (3) tick(1'b0, '0);
        i_rst = 1'b0;
        check("rst_tx",   {31'd0, o_uart_tx},  32'd1);
        check("rst_busy", {31'd0, o_busy},     32'd0);
        check("rst_ovf",  {31'd0, o_overflow}, 32'd0);
        check("rst_cnt",  {28'd0, o_fifo_count}, 32'd0);
        repeat (50) tick(1'b0, '0);
        check("quiet_busy", {31'd0, o_busy}, 32'd0);

        // 2: single word
        tick(1'b1, 32'h12345678);
        check("t2_cnt_after_push", {28'd0, o_fifo_count}, 32'd1);
        tick(1'b0, '0);
        e1 = ecount;
        check("t2_tx_low_after_e1", {31'd0, o_uart_tx}, 32'd0);
        wait_idle(400);
        check("t2_word", decode(e1), 32'h12345678);
        check("t2_byte0", {24'd0, decode(e1) & 32'hFF}, 32'h78);
        check_frames("t2", e1, 4);
        check("t2_busy_159", {31'd0, busy_hist[e1 + WORDC - 1]}, 32'd1);
        check("t2_busy_160", {31'd0, busy_hist[e1 + WORDC]},     32'd0);

        // 3: back-to-back words, no gap
        tick(1'b1, 32'h00000000);
        tick(1'b1, 32'hFFFFFFFF);
        e1 = ecount;
        wait_idle(800);
        check("t3_word0", decode(e1), 32'h00000000);
        check("t3_word1", decode(e1 + WORDC), 32'hFFFFFFFF);
        check_frames("t3", e1, 8);
        check("t3_busy_319", {31'd0, busy_hist[e1 + 2*WORDC - 1]}, 32'd1);
        check("t3_busy_320", {31'd0, busy_hist[e1 + 2*WORDC]},     32'd0);

        // 4: ten-word burst, tenth dropped
        for (int i = 0; i < 10; i++) begin
            words[i] = $urandom;
            tick(1'b1, words[i]);
            if (i == 0) e1 = ecount + 1;
        end
        check("t4_ovf_set", {31'd0, o_overflow}, 32'd1);
        check("t4_cnt_full", {28'd0, o_fifo_count}, 32'd8);
        wait_idle(2000);
        for (int i = 0; i < 9; i++) check("t4_word", decode(e1 + i*WORDC), words[i]);
        check("t4_idle_after_9", {31'd0, busy_hist[e1 + 9*WORDC]}, 32'd0);
        check("t4_ovf_sticky", {31'd0, o_overflow}, 32'd1);

        // 5: push while full at the pop edge
        do_reset();
        tick(1'b0, '0);
        check("t5_ovf_cleared", {31'd0, o_overflow}, 32'd0);
        for (int i = 0; i < 11; i++) words[i] = $urandom;
        tick(1'b1, words[0]);
        e1 = ecount + 1;
        for (int i = 1; i <= 8; i++) tick(1'b1, words[i]);
        check("t5_full", {28'd0, o_fifo_count}, 32'd8);
        while (ecount < e1 + WORDC - 1) tick(1'b0, '0);
        tick(1'b1, words[9]);
        check("t5_cnt_same", {28'd0, o_fifo_count}, 32'd8);
        check("t5_no_ovf",   {31'd0, o_overflow},   32'd0);
        tick(1'b1, words[10]);
        check("t5_drop_ovf", {31'd0, o_overflow},   32'd1);
        wait_idle(3000);
        check("t5_word9", decode(e1 + 9*WORDC), words[9]);

        // 6: reset during DATA bit 3 of byte 1
        do_reset();
        tick(1'b1, 32'hDEADBEEF);
        e1 = ecount + 1;
        tick(1'b1, 32'hCAFEF00D);
        while (ecount < e1 + 10*CD + CD + 3*CD + 1) tick(1'b0, '0);
        do_reset();
        check("t6_tx",   {31'd0, o_uart_tx},  32'd1);
        check("t6_cnt",  {28'd0, o_fifo_count}, 32'd0);
        check("t6_busy", {31'd0, o_busy},     32'd0);
        repeat (8) tick(1'b0, '0);
        check("t6_stays_idle", {31'd0, o_busy}, 32'd0);
        tick(1'b1, 32'h000000A5);
        e1 = ecount + 1;
        wait_idle(400);
        check("t6_word", decode(e1), 32'h000000A5);

        // Random traffic with occasional bursts
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) < 3) begin
                for (int b = 0; b < int'($urandom_range(1, 12)); b++) tick(1'b1, $urandom);
            end else begin
                tick($urandom_range(0, 99) < 1, $urandom);
            end
        end
        wait_idle(3000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
